five_click_detector: RTL and testbench

- Upstream of the cheat handler; generates the single-cycle `five_r_click` strobe from the mouse right-button level.
- Counts rising edges of the right button within a fixed time window measured from the first press.
- Fires once when the count reaches CLICK_TARGET, then enters a cooldown so held or extra clicks cannot re-trigger immediately.

---
 rtl/five_click_detector_pkg.sv | 20 ++
 rtl/five_click_detector_if.sv | 20 ++
 rtl/five_click_detector_edge_detect.sv | 22 ++
 rtl/five_click_detector.sv | 111 +++++++++++
 tb/tb_five_click_detector.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/five_click_detector_pkg.sv
// Shared types and default timing for the five-click detector.
// Optional left-button cancel is enabled by FIVE_CLICK_LEFT_CANCEL_EN.
package five_click_detector_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } fcd_state_t;

  localparam int DEF_CLICK_TARGET    = 5;
  localparam int DEF_WINDOW_CYCLES   = 100_000_000;
  localparam int DEF_COOLDOWN_CYCLES = 50_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/five_click_detector_if.sv
// Button-level inputs and strobe/debug outputs of the detector.
// Stimulus side is master, detector side is slave.
interface five_click_detector_if;
  logic       en;
  logic       r_click;
  logic       l_click;
  logic       five_r_click;
  logic [3:0] click_cnt;
  logic       busy;

  modport master (
    output en, r_click, l_click,
    input  five_r_click, click_cnt, busy
  );

  modport slave (
    input  en, r_click, l_click,
    output five_r_click, click_cnt, busy
  );
endinterface

// File: rtl/five_click_detector_edge_detect.sv
// Rising-edge detector with configurable previous-value reset.
// RST_VAL=1 keeps a button held across reset from looking like a press.
module click_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_prev;

  // remember last level every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= RST_VAL;
    else        r_prev <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_prev;

endmodule

// File: rtl/five_click_detector.sv
// Counts right-click edges in a window; strobes once at the target.
// FIVE_CLICK_LEFT_CANCEL_EN: a left-click edge aborts counting.
module five_click_detector
  import five_click_detector_pkg::*;
#(
  parameter int CLICK_TARGET    = DEF_CLICK_TARGET,
  parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  five_click_detector_if.slave bus
);

  localparam int TW =
    $clog2(max_int(WINDOW_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam logic [3:0] CNT_TGT = 4'(CLICK_TARGET);
  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] CD_LAST = TW'(COOLDOWN_CYCLES - 1);

  fcd_state_t    r_state;
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_inc;
  logic          w_r_edge;
  logic          w_l_cancel;

  click_edge_detect #(.RST_VAL(1'b1)) u_r_edge (
    .clk   (clk),
    .rst_n (rst),
    .i_lvl (bus.r_click),
    .o_rise(w_r_edge)
  );

`ifdef FIVE_CLICK_LEFT_CANCEL_EN
  click_edge_detect #(.RST_VAL(1'b1)) u_l_edge (
    .clk   (clk),
    .rst_n (rst),
    .i_lvl (bus.l_click),
    .o_rise(w_l_cancel)
  );
`else
  logic w_unused_l;
  assign w_unused_l = bus.l_click;
  assign w_l_cancel = 1'b0;
`endif

  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;

  // window/cooldown FSM with saturating timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_timer <= '0;
          if (bus.en && w_r_edge) begin
            r_state <= COUNTING;
            r_cnt   <= 4'd1;
          end
        end
        COUNTING: begin
          r_timer <= w_timer_inc;
          if (!bus.en || w_l_cancel) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_timer <= '0;
          end else if (w_r_edge) begin
            if (r_cnt + 4'd1 == CNT_TGT) begin
              r_state <= FIRE;
              r_cnt   <= CNT_TGT;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else if (r_timer == WIN_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_timer <= '0;
          end
        end
        FIRE: begin
          r_state <= COOLDOWN;
          r_cnt   <= '0;
          r_timer <= '0;
        end
        COOLDOWN: begin
          r_cnt   <= '0;
          r_timer <= w_timer_inc;
          if (r_timer == CD_LAST) begin
            r_state <= IDLE;
            r_timer <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign bus.five_r_click = (r_state == FIRE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.click_cnt    = r_cnt;

endmodule

// File: tb/tb_five_click_detector.sv
// Directed bench for five_click_detector (target 5, window 50, cooldown 20).
// Expectations adapt to FIVE_CLICK_LEFT_CANCEL_EN when defined.
module tb_five_click_detector;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_strobe;

  five_click_detector_if bus();

  five_click_detector #(
    .CLICK_TARGET   (5),
    .WINDOW_CYCLES  (50),
    .COOLDOWN_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.five_r_click === 1'b1) n_strobe++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input string nm, input logic [3:0] cnt,
                       input logic fire);
    bus.r_click = 1'b1;
    tick();
    chk({nm, " cnt"}, bus.click_cnt, cnt);
    chk({nm, " strobe"}, {3'b0, bus.five_r_click}, {3'b0, fire});
    chk({nm, " busy"}, {3'b0, bus.busy}, 4'd1);
    tick();
    bus.r_click = 1'b0;
    chk({nm, " strobe2"}, {3'b0, bus.five_r_click}, 4'd0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.en = 1'b1;
    bus.r_click = 1'b0;
    bus.l_click = 1'b0;
    repeat (3) tick();
    chk("rst cnt", bus.click_cnt, 4'd0);
    chk("rst busy", {3'b0, bus.busy}, 4'd0);
    chk("rst strobe", {3'b0, bus.five_r_click}, 4'd0);
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_five();
    int s0 = n_strobe;
    for (int k = 1; k <= 5; k++)
      pulse("five", 4'(k), k == 5);
    chk("five cool cnt", bus.click_cnt, 4'd0);
    chk("five cool busy", {3'b0, bus.busy}, 4'd1);
    repeat (25) tick();
    chk("five nstrobe", 4'(n_strobe - s0), 4'd1);
    chk("five idle", {3'b0, bus.busy}, 4'd0);
  endtask

  task automatic test_timeout();
    int s0 = n_strobe;
    for (int k = 1; k <= 4; k++) pulse("tmo", 4'(k), 1'b0);
    repeat (26) tick();
    chk("tmo cnt49", bus.click_cnt, 4'd4);
    chk("tmo busy49", {3'b0, bus.busy}, 4'd1);
    tick();
    chk("tmo cnt50", bus.click_cnt, 4'd0);
    chk("tmo busy50", {3'b0, bus.busy}, 4'd0);
    repeat (10) tick();
    chk("tmo nstrobe", 4'(n_strobe - s0), 4'd0);
  endtask

  task automatic test_last_cycle();
    for (int k = 1; k <= 4; k++) pulse("last", 4'(k), 1'b0);
    repeat (26) tick();
    pulse("last5", 4'd5, 1'b1);
    repeat (25) tick();
  endtask

  task automatic test_cooldown();
    int s0 = n_strobe;
    for (int k = 1; k <= 5; k++) pulse("cd", 4'(k), k == 5);
    for (int k = 0; k < 5; k++) begin
      bus.r_click = 1'b1;
      tick();
      bus.r_click = 1'b0;
      tick();
      chk("cd ign cnt", bus.click_cnt, 4'd0);
    end
    chk("cd busy", {3'b0, bus.busy}, 4'd1);
    repeat (10) tick();
    chk("cd idle", {3'b0, bus.busy}, 4'd0);
    for (int k = 1; k <= 5; k++) pulse("cd2", 4'(k), k == 5);
    repeat (25) tick();
    chk("cd nstrobe", 4'(n_strobe - s0), 4'd2);
  endtask

  task automatic test_hold_reset();
    rst = 1'b0;
    bus.r_click = 1'b1;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("hold cnt", bus.click_cnt, 4'd0);
    chk("hold busy", {3'b0, bus.busy}, 4'd0);
    bus.r_click = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_en_drop();
    for (int k = 1; k <= 3; k++) pulse("en", 4'(k), 1'b0);
    bus.en = 1'b0;
    tick();
    chk("en cnt", bus.click_cnt, 4'd0);
    chk("en busy", {3'b0, bus.busy}, 4'd0);
    bus.en = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int s0 = n_strobe;
    for (int k = 1; k <= 4; k++) pulse("rmid", 4'(k), 1'b0);
    bus.r_click = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rmid cnt", bus.click_cnt, 4'd0);
    chk("rmid busy", {3'b0, bus.busy}, 4'd0);
    tick();
    rst = 1'b1;
    bus.r_click = 1'b0;
    repeat (5) tick();
    chk("rmid nstrobe", 4'(n_strobe - s0), 4'd0);
  endtask

  task automatic test_left_cancel();
    int s0 = n_strobe;
    for (int k = 1; k <= 3; k++) pulse("lc", 4'(k), 1'b0);
    bus.l_click = 1'b1;
    tick();
    bus.l_click = 1'b0;
`ifdef FIVE_CLICK_LEFT_CANCEL_EN
    chk("lc cnt", bus.click_cnt, 4'd0);
    chk("lc busy", {3'b0, bus.busy}, 4'd0);
    tick();
    pulse("lc r1", 4'd1, 1'b0);
    pulse("lc r2", 4'd2, 1'b0);
`else
    chk("lc cnt", bus.click_cnt, 4'd3);
    chk("lc busy", {3'b0, bus.busy}, 4'd1);
    tick();
    pulse("lc r4", 4'd4, 1'b0);
    pulse("lc r5", 4'd5, 1'b1);
`endif
    repeat (70) tick();
    for (int k = 1; k <= 4; k++) pulse("sim", 4'(k), 1'b0);
    bus.r_click = 1'b1;
    bus.l_click = 1'b1;
    tick();
`ifdef FIVE_CLICK_LEFT_CANCEL_EN
    chk("sim cnt", bus.click_cnt, 4'd0);
    chk("sim strobe", {3'b0, bus.five_r_click}, 4'd0);
`else
    chk("sim cnt", bus.click_cnt, 4'd5);
    chk("sim strobe", {3'b0, bus.five_r_click}, 4'd1);
`endif
    bus.r_click = 1'b0;
    bus.l_click = 1'b0;
    repeat (30) tick();
`ifdef FIVE_CLICK_LEFT_CANCEL_EN
    chk("lc nstrobe", 4'(n_strobe - s0), 4'd0);
`else
    chk("lc nstrobe", 4'(n_strobe - s0), 4'd2);
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    n_strobe = 0;
    test_reset();
    test_five();
    test_timeout();
    test_last_cycle();
    test_cooldown();
    test_hold_reset();
    test_en_drop();
    test_reset_mid();
    test_left_cancel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
